// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and ARM/RUN/DONE fetch sequencer (optional FETCH_PERF_EN cycle/jump counters)
module fetch_unit #(
    parameter int PC_W     = 10,
    parameter int P1_START = 0,
    parameter int P2_START = 'h100,
    parameter int P3_START = 'h200
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [1:0]      ProgSel,
    input  logic            jump_en,
    input  logic [15:0]     Target,
    input  logic            Halt,
    output logic [PC_W-1:0] ProgCtr,
    output logic            InstrValid,
    output logic            Done,
    output logic [15:0]     CycleCnt,
    output logic [15:0]     JumpCnt
);

    typedef enum logic [1:0] {S_ARM, S_RUN, S_DONE} state_t;

    localparam logic [PC_W-1:0] L_P1 = PC_W'(P1_START);
    localparam logic [PC_W-1:0] L_P2 = PC_W'(P2_START);
    localparam logic [PC_W-1:0] L_P3 = PC_W'(P3_START);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic            r_done;
    logic [PC_W-1:0] w_start;
    logic            w_unused_tgt;

    assign w_unused_tgt = &{1'b0, Target[15:PC_W]};

    // ProgSel 0 is an alias for program 1
    always_comb begin
        case (ProgSel)
            2'd2:    w_start = L_P2;
            2'd3:    w_start = L_P3;
            default: w_start = L_P1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_ARM;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ARM:   if (!Start) w_next = S_RUN;
            S_RUN: begin
                if (Start)     w_next = S_ARM;
                else if (Halt) w_next = S_DONE;
            end
            S_DONE:  if (Start) w_next = S_ARM;
            default: w_next = S_ARM;
        endcase
    end

    // next-PC priority in RUN: Start > Halt > jump_en > increment
    always_comb begin
        w_pc_next  = r_pc;
        InstrValid = (r_state == S_RUN);
        case (r_state)
            S_ARM: w_pc_next = w_start;
            S_RUN: begin
                if (Start)        w_pc_next = w_start;
                else if (Halt)    w_pc_next = r_pc;
                else if (jump_en) w_pc_next = Target[PC_W-1:0];
                else              w_pc_next = r_pc + 1'b1;
            end
            S_DONE: if (Start) w_pc_next = w_start;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc   <= '0;
            r_done <= 1'b0;
        end else begin
            r_pc   <= w_pc_next;
            r_done <= (w_next == S_DONE);
        end
    end

    assign ProgCtr = r_pc;
    assign Done    = r_done;

`ifdef FETCH_PERF_EN
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_jump_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || r_state == S_ARM) begin
            r_cycle_cnt <= '0;
            r_jump_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            if (r_cycle_cnt != 16'hFFFF)
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            if (jump_en && !Halt && r_jump_cnt != 16'hFFFF)
                r_jump_cnt <= r_jump_cnt + 16'd1;
        end
    end

    assign CycleCnt = r_cycle_cnt;
    assign JumpCnt  = r_jump_cnt;
`else
    assign CycleCnt = 16'd0;
    assign JumpCnt  = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  ProgSel = 2'd0;
    logic        jump_en = 1'b0;
    logic [15:0] Target = 16'd0;
    logic        Halt = 1'b0;
    logic [9:0]  ProgCtr;
    logic        InstrValid;
    logic        Done;
    logic [15:0] CycleCnt;
    logic [15:0] JumpCnt;

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .jump_en(jump_en), .Target(Target), .Halt(Halt),
        .ProgCtr(ProgCtr), .InstrValid(InstrValid), .Done(Done),
        .CycleCnt(CycleCnt), .JumpCnt(JumpCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int idx;
        bit all;
        int pc;
        int v;
        int d;
        int c;
        int j;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int step_no = 0;

    function automatic int pf(input int x);
`ifdef FETCH_PERF_EN
        return x;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    // monitor: one expected record per cycle, compared away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("InstrValid", e.idx, int'(InstrValid), e.v);
                chk("Done", e.idx, int'(Done), e.d);
                if (e.all) begin
                    chk("ProgCtr", e.idx, int'(ProgCtr), e.pc);
                    chk("CycleCnt", e.idx, int'(CycleCnt), pf(e.c));
                    chk("JumpCnt", e.idx, int'(JumpCnt), pf(e.j));
                end
            end
        end
    end

    // drive inputs for the next edge, then queue the outputs expected after it
    task automatic cyc(input bit rst, input bit st, input int sel, input bit je,
                       input int tgt, input bit hlt, input bit all,
                       input int epc, input int ev, input int ed, input int ec, input int ej);
        exp_t e;
        Reset = rst; Start = st; ProgSel = 2'(sel); jump_en = je;
        Target = 16'(tgt); Halt = hlt;
        @(posedge Clk);
        #1;
        step_no++;
        e.idx = step_no; e.all = all; e.pc = epc; e.v = ev; e.d = ed; e.c = ec; e.j = ej;
        q.push_back(e);
    endtask

    task automatic run(input int epc, input int ec, input int ej);
        cyc(0, 0, 0, 0, 0, 0, 1, epc, 1, 0, ec, ej);
    endtask

    initial begin
        #1;
        // reset state
        cyc(1, 0, 0, 0, 0, 0, 1, 'h000, 0, 0, 0, 0);
        // program 2 armed for three cycles then launched
        cyc(0, 1, 2, 0, 0, 0, 1, 'h100, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0, 1, 'h100, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0, 1, 'h100, 0, 0, 0, 0);
        cyc(0, 0, 2, 0, 0, 0, 1, 'h100, 1, 0, 0, 0);
        run('h101, 1, 0);
        run('h102, 2, 0);
        // jump to 5, then jump with upper Target bits set
        cyc(0, 0, 0, 1, 'h0005, 0, 1, 'h005, 1, 0, 3, 1);
        cyc(0, 0, 0, 1, 'hFC03, 0, 1, 'h003, 1, 0, 4, 2);
        run('h004, 5, 2);
        // wrap from all-ones
        cyc(0, 0, 0, 1, 'h03FF, 0, 1, 'h3FF, 1, 0, 6, 3);
        run('h000, 7, 3);
        run('h001, 8, 3);
        // reset mid-run
        cyc(0, 0, 0, 1, 'h0123, 0, 1, 'h123, 1, 0, 9, 4);
        cyc(1, 1, 0, 1, 'h0055, 1, 1, 'h000, 0, 0, 0, 0);
        // program 1, halt together with jump at 7
        cyc(0, 1, 1, 0, 0, 0, 1, 'h000, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1, 'h000, 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) run(i, i, 0);
        cyc(0, 0, 0, 1, 'h0055, 1, 1, 'h007, 0, 1, 8, 0);
        cyc(0, 0, 0, 1, 'h0055, 1, 1, 'h007, 0, 1, 8, 0);
        // restart from DONE with ProgSel=0
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 'h000, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 'h000, 1, 0, 0, 0);
        run('h001, 1, 0);
        // Start outranks Halt in RUN, then program 3 halts immediately
        cyc(0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 1, 'h200, 0, 0, 0, 0);
        cyc(0, 0, 3, 0, 0, 0, 1, 'h200, 1, 0, 0, 0);
        cyc(0, 0, 3, 0, 0, 1, 1, 'h200, 0, 1, 1, 0);
        // jump/halt ignored in DONE
        cyc(0, 0, 3, 1, 'h0010, 0, 1, 'h200, 0, 1, 1, 0);
        Start = 1'b1;
        repeat (3) @(negedge Clk);
        chk("queue_drained", step_no, q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", step_no);
        $fatal(1);
    end

endmodule
